// File: rtl/fb_scheduler_if.sv
// Signal bundle for fb_scheduler: pixel-writer stream, display read port and framebuffer pins.
// The scheduler takes the slave modport; the surrounding system takes master.
interface fb_scheduler_if;
  logic       frame_start;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_frame_done;
  logic       rd_frame_start;
  logic       rd_req;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_overrun;
  logic       fb_write_mode;
  logic       fb_ptr_reset;
  logic       fb_doit;
  logic [3:0] fb_in;
  logic [3:0] fb_out;

  modport master (
    output frame_start, wr_data, wr_valid, rd_frame_start, rd_req, fb_out,
    input  wr_ready, wr_frame_done, rd_data, rd_valid, rd_overrun,
    input  fb_write_mode, fb_ptr_reset, fb_doit, fb_in
  );

  modport slave (
    input  frame_start, wr_data, wr_valid, rd_frame_start, rd_req, fb_out,
    output wr_ready, wr_frame_done, rd_data, rd_valid, rd_overrun,
    output fb_write_mode, fb_ptr_reset, fb_doit, fb_in
  );
endinterface

// File: rtl/fb_scheduler.sv
// Single-port framebuffer scheduler: one command per cycle, display reads win over the
// FIFO-buffered pixel writer, and frame pointer resets are sequenced for both sides.
module fb_scheduler #(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  fb_scheduler_if.slave bus
);
  localparam int unsigned CntW  = 17;
  localparam int unsigned AddrW = $clog2(WFIFO_DEPTH);
  localparam logic [CntW-1:0]  FrameN   = CntW'(WIDTH * HEIGHT);
  localparam logic [CntW-1:0]  LastPix  = CntW'(WIDTH * HEIGHT - 1);
  localparam logic [AddrW:0]   FifoFull = (AddrW + 1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {WIdle, WRst, WActive} wstate_e;

  wstate_e          wstate_q;
  logic             rrst_pend_q, rd_pend_q, rd_issue_q, rd_valid_q, rd_overrun_q, done_q;
  logic [3:0]       rd_data_q;
  logic [CntW-1:0]  acc_cnt_q, wr_cnt_q;
  logic [3:0]       fifo_q [WFIFO_DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   count_q;

  logic cmd_rrst, cmd_read, cmd_wrst, cmd_write;
  logic fifo_full, wr_ready, push, pop;

  // Commands depend only on registered state so no input reaches the framebuffer pins.
  always_comb begin
    cmd_rrst  = rrst_pend_q;
    cmd_read  = !rrst_pend_q && rd_pend_q;
    cmd_wrst  = !rrst_pend_q && !rd_pend_q && (wstate_q == WRst);
    cmd_write = !rrst_pend_q && !rd_pend_q && (wstate_q == WActive) && (count_q != '0);
    fifo_full = (count_q == FifoFull);
    wr_ready  = (wstate_q == WActive) && !fifo_full && (acc_cnt_q < FrameN);
    push      = wr_ready && bus.wr_valid && !bus.frame_start;
    pop       = cmd_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q     <= WIdle;
      rrst_pend_q  <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_issue_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_overrun_q <= 1'b0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < WFIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      rrst_pend_q <= (rrst_pend_q && !cmd_rrst) || bus.rd_frame_start;
      // A second request before the first READ issues is merged and flagged.
      rd_pend_q   <= (rd_pend_q && !cmd_read) || bus.rd_req;
      if (bus.rd_req && rd_pend_q) rd_overrun_q <= 1'b1;
      rd_issue_q <= cmd_read;
      rd_valid_q <= rd_issue_q;
      if (rd_issue_q) rd_data_q <= bus.fb_out;
      done_q <= 1'b0;

      if (push) begin
        fifo_q[wptr_q] <= bus.wr_data;
        wptr_q         <= wptr_q + 1'b1;
        acc_cnt_q      <= acc_cnt_q + CntW'(1);
      end
      if (pop) begin
        rptr_q   <= rptr_q + 1'b1;
        wr_cnt_q <= wr_cnt_q + CntW'(1);
      end
      count_q <= count_q + (AddrW + 1)'(push) - (AddrW + 1)'(pop);

      case (wstate_q)
        WIdle: if (bus.frame_start) wstate_q <= WRst;
        WRst: begin
          if (cmd_wrst) begin
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wstate_q  <= WActive;
          end
        end
        WActive: begin
          if (pop && (wr_cnt_q == LastPix)) begin
            done_q   <= 1'b1;
            wstate_q <= WIdle;
          end
        end
        default: wstate_q <= WIdle;
      endcase

      // A new frame abandons whatever the writer had buffered.
      if (bus.frame_start) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        count_q  <= '0;
        done_q   <= 1'b0;
        wstate_q <= WRst;
      end
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.wr_frame_done = done_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_overrun    = rd_overrun_q;
  assign bus.fb_ptr_reset  = cmd_rrst || cmd_wrst;
  assign bus.fb_doit       = cmd_read || cmd_write;
  assign bus.fb_write_mode = cmd_wrst || cmd_write;
  assign bus.fb_in         = fifo_q[rptr_q];
endmodule

// File: tb/tb_fb_scheduler.sv
// Scoreboard bench for fb_scheduler on a reduced 40x12 frame with a behavioural framebuffer.
module tb_fb_scheduler;
  localparam int W = 40;
  localparam int H = 12;
  localparam int N = W * H;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_scheduler_if bus ();
  fb_scheduler #(.WIDTH(W), .HEIGHT(H), .WFIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Framebuffer: independent read/write pointers, registered read data.
  logic [3:0] fram [N];
  int  frp = 0;
  int  fwp = 0;
  bit  preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) fram[i] <= 4'(i % 16);
    end else if (bus.fb_ptr_reset) begin
      if (bus.fb_write_mode) fwp <= 0;
      else frp <= 0;
    end else if (bus.fb_doit) begin
      if (bus.fb_write_mode) begin
        if (fwp < N) fram[fwp] <= bus.fb_in;
        fwp <= fwp + 1;
      end else begin
        if (frp < N) bus.fb_out <= fram[frp];
        frp <= frp + 1;
      end
    end
  end

  // Reference model state, owned by the monitor.
  typedef struct { int at; logic [3:0] data; } rd_exp_t;
  typedef struct { int idx; logic [3:0] data; } wr_exp_t;
  rd_exp_t    rdq[$];
  wr_exp_t    wq[$];
  rd_exp_t    re;
  wr_exp_t    we;
  logic [3:0] mram_w [N];
  int m_rptr, m_acc, rd_issue_at, done_due, n_done;
  bit m_ovr, m_idle;

  always @(negedge clk) begin
    if (rst) begin
      rdq.delete();
      wq.delete();
      m_rptr = 0; m_acc = 0; rd_issue_at = -10; done_due = -1; m_ovr = 0; m_idle = 1;
    end else begin
      check("wr_frame_done", int'(bus.wr_frame_done), int'(done_due == cyc));
      if (bus.wr_frame_done) n_done++;
      check("rd_overrun", int'(bus.rd_overrun), int'(m_ovr));
      if (m_idle || m_acc == N) check("wr_ready_low", int'(bus.wr_ready), 0);
      if (bus.rd_valid) begin
        if (rdq.size() == 0) check("rd_valid_unexpected", 1, 0);
        else begin
          re = rdq.pop_front();
          check("rd_latency", cyc, re.at);
          check("rd_data", int'(bus.rd_data), int'(re.data));
        end
      end else if (rdq.size() > 0 && rdq[0].at <= cyc) begin
        re = rdq.pop_front();
        check("rd_valid_missing", 0, 1);
      end
      if (bus.fb_doit && bus.fb_write_mode) begin
        if (wq.size() == 0) check("write_unexpected", 1, 0);
        else begin
          we = wq.pop_front();
          check("fb_in", int'(bus.fb_in), int'(we.data));
          if (we.idx == N - 1) begin
            done_due = cyc + 1;
            m_idle   = 1;
          end
        end
      end
      // Input side: record what each accepted pixel and request must produce.
      if (bus.wr_valid && bus.wr_ready && !bus.frame_start && m_acc < N) begin
        we.idx = m_acc;
        we.data = bus.wr_data;
        wq.push_back(we);
        mram_w[m_acc] = bus.wr_data;
        m_acc++;
      end
      if (bus.frame_start) begin
        wq.delete();
        m_acc  = 0;
        m_idle = 0;
      end
      if (bus.rd_frame_start) m_rptr = 0;
      if (bus.rd_req) begin
        if (rd_issue_at >= cyc) m_ovr = 1;
        if (rd_issue_at <= cyc) begin
          rd_issue_at = cyc + (bus.rd_frame_start ? 2 : 1);
          re.at   = rd_issue_at + 2;
          re.data = 4'(m_rptr % 16);
          rdq.push_back(re);
          m_rptr++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_ram();
    preload = 1'b1;
    step();
    preload = 1'b0;
  endtask

  task automatic stream(int npix, bit rnd_data, bit rnd_valid);
    int sent = 0;
    int budget = 40 * npix + 200;
    logic [3:0] d = '0;
    bit fresh = 1'b1;
    while (sent < npix && budget > 0) begin
      if (fresh) d = rnd_data ? 4'($urandom) : 4'(sent % 16);
      bus.wr_data  = d;
      bus.wr_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      fresh = bus.wr_valid && bus.wr_ready;
      if (fresh) sent++;
      step();
      budget--;
    end
    bus.wr_valid = 1'b0;
    if (sent < npix) check("stream_timeout", sent, npix);
  endtask

  task automatic drain();
    int b = 0;
    while ((wq.size() > 0 || rdq.size() > 0) && b < 300) begin
      step();
      b++;
    end
    if (b == 300) check("drain_timeout", wq.size() + rdq.size(), 0);
    repeat (4) step();
  endtask

  task automatic check_ram(string name);
    int bad = 0;
    for (int i = 0; i < N; i++) if (fram[i] !== mram_w[i]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.frame_start = 0; bus.wr_data = 0; bus.wr_valid = 0;
    bus.rd_frame_start = 0; bus.rd_req = 0;
    n_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("boot_rrst_ptr_reset", int'(bus.fb_ptr_reset), 1);
    check("boot_rrst_write_mode", int'(bus.fb_write_mode), 0);
    check("boot_rrst_doit", int'(bus.fb_doit), 0);
    @(negedge clk);
    check("idle_ptr_reset", int'(bus.fb_ptr_reset), 0);
    check("idle_doit", int'(bus.fb_doit), 0);
    check("idle_write_mode", int'(bus.fb_write_mode), 0);
    check("idle_rd_valid", int'(bus.rd_valid), 0);
    step();

    // Display reads from a preloaded frame.
    preload_ram();
    bus.rd_frame_start = 1; bus.rd_req = 1;
    step();
    bus.rd_frame_start = 0; bus.rd_req = 0;
    @(negedge clk);
    check("rd_rrst_ptr_reset", int'(bus.fb_ptr_reset), 1);
    check("rd_rrst_write_mode", int'(bus.fb_write_mode), 0);
    @(negedge clk);
    check("rd_read_doit", int'(bus.fb_doit), 1);
    check("rd_read_write_mode", int'(bus.fb_write_mode), 0);
    step();
    step();
    for (int i = 0; i < 24; i++) begin
      bus.rd_req = 1; step(); bus.rd_req = 0; repeat (3) step();
    end
    for (int i = 0; i < 24; i++) begin
      bus.rd_req = 1; step(); bus.rd_req = 0; repeat ($urandom_range(1, 4)) step();
    end
    drain();

    // Request merged while RRST holds off the pending read.
    bus.rd_frame_start = 1; bus.rd_req = 1;
    step();
    bus.rd_frame_start = 0;
    step();
    bus.rd_req = 0;
    repeat (20) step();
    check("overrun_sticky", int'(bus.rd_overrun), 1);
    drain();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("overrun_cleared", int'(bus.rd_overrun), 0);
    repeat (3) step();

    // Full frame, counting stream, no reads.
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    @(negedge clk);
    check("wrst_ptr_reset", int'(bus.fb_ptr_reset), 1);
    check("wrst_write_mode", int'(bus.fb_write_mode), 1);
    step();
    stream(N, 1'b0, 1'b0);
    drain();
    check("frame1_done_count", n_done, 1);
    check_ram("frame1_ram");

    // Reads every second cycle while the writer streams random pixels.
    preload_ram();
    fork
      begin
        bus.rd_frame_start = 1; step(); bus.rd_frame_start = 0; step();
        for (int i = 0; i < N; i++) begin
          bus.rd_req = 1; step(); bus.rd_req = 0; step();
        end
      end
      begin
        repeat (4) step();
        bus.frame_start = 1; step(); bus.frame_start = 0;
        stream(N, 1'b1, 1'b0);
      end
    join
    drain();
    check("frame2_done_count", n_done, 2);
    check_ram("frame2_ram");

    // Abort a frame part-way, then complete a fresh one.
    bus.frame_start = 1; step(); bus.frame_start = 0; step();
    stream(100, 1'b1, 1'b1);
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    @(negedge clk);
    check("abort_wrst_ptr_reset", int'(bus.fb_ptr_reset), 1);
    check("abort_wrst_write_mode", int'(bus.fb_write_mode), 1);
    step();
    repeat (5) step();
    check("abort_no_done", n_done, 2);
    stream(N, 1'b1, 1'b1);
    drain();
    check("frame3_done_count", n_done, 3);
    check_ram("frame3_ram");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
